// File: rtl/piso_tx_pkg.sv
// Shared types and constants for the PISO transmit controller.
package piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/piso_shifter.sv
// Load/shift-left register with zero fill; the controller decides when to load or shift.
module piso_shifter
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_msb
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end else if (i_shift) begin
            r_data <= {r_data[WIDTH-2:0], 1'b0};
        end
    end

    assign o_msb = r_data[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Two-requester round-robin PISO transmit sequencer, MSB-first with frame strobes.
// Define PISO_TX_PARITY_EN to append an even-parity bit to every frame.
module piso_tx_ctrl
    import piso_tx_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             grant_id,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
`ifndef PISO_TX_PARITY_EN
    localparam logic [CNT_W-1:0] PEN_CNT  = CNT_W'(WIDTH - 2);
`endif

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;

    logic             w_in_idle;
    logic             w_gnt0;
    logic             w_gnt1;
    logic             w_hs;
    logic             w_winner;
    logic [WIDTH-1:0] w_word;
    logic             w_shift;
    logic             w_sh_msb;

    logic             w_nxt_ser_out;
    logic             w_nxt_first;
    logic             w_nxt_last;
    logic             w_nxt_active;

    logic             r_ser_out;
    logic             r_ser_valid;
    logic             r_ser_first;
    logic             r_ser_last;
    logic             r_grant_id;
    logic             r_busy;

`ifdef PISO_TX_PARITY_EN
    logic             r_parity;
`endif

    // On a tie the requester that was not granted last wins; ready is forced low in reset.
    assign w_in_idle = rst_n && (r_state == IDLE);
    assign w_gnt0    = w_in_idle && req0_valid && (!req1_valid || (r_last_grant == REQ1));
    assign w_gnt1    = w_in_idle && req1_valid && (!req0_valid || (r_last_grant == REQ0));
    assign w_hs      = w_gnt0 || w_gnt1;
    assign w_winner  = w_gnt1 ? REQ1 : REQ0;
    assign w_word    = w_gnt1 ? req1_data : req0_data;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    assign w_shift = (r_state == SHIFT);

    // The MSB goes straight into the output register, so the shifter keeps only the remaining bits.
    piso_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_hs),
        .i_shift (w_shift),
        .i_data  ({w_word[WIDTH-2:0], 1'b0}),
        .o_msb   (w_sh_msb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == LAST_CNT) begin
`ifdef PISO_TX_PARITY_EN
                    w_next_state = PARITY;
`else
                    w_next_state = IDLE;
`endif
                end
            end
`ifdef PISO_TX_PARITY_EN
            PARITY: begin
                w_next_state = IDLE;
            end
`endif
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Outputs are computed one cycle ahead and registered, so each lines up with its frame cycle.
    always_comb begin
        w_nxt_ser_out = 1'b0;
        w_nxt_first   = 1'b0;
        w_nxt_last    = 1'b0;
        w_nxt_active  = (w_next_state != IDLE);
        case (r_state)
            IDLE: begin
                if (w_hs) begin
                    w_nxt_ser_out = w_word[WIDTH-1];
                    w_nxt_first   = 1'b1;
                end
            end
            SHIFT: begin
`ifdef PISO_TX_PARITY_EN
                if (r_cnt == LAST_CNT) begin
                    w_nxt_ser_out = r_parity;
                    w_nxt_last    = 1'b1;
                end else begin
                    w_nxt_ser_out = w_sh_msb;
                end
`else
                w_nxt_ser_out = w_sh_msb;
                w_nxt_last    = (r_cnt == PEN_CNT);
`endif
            end
            default: begin
                w_nxt_ser_out = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_last_grant <= REQ1;
            r_grant_id   <= REQ0;
        end else if (w_hs) begin
            r_cnt        <= '0;
            r_last_grant <= w_winner;
            r_grant_id   <= w_winner;
        end else if (r_state == SHIFT) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

`ifdef PISO_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_parity <= 1'b0;
        end else if (w_hs) begin
            r_parity <= ^w_word;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_first <= 1'b0;
            r_ser_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_ser_out   <= w_nxt_ser_out;
            r_ser_valid <= w_nxt_active;
            r_ser_first <= w_nxt_first;
            r_ser_last  <= w_nxt_last;
            r_busy      <= w_nxt_active;
        end
    end

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign ser_first = r_ser_first;
    assign ser_last  = r_ser_last;
    assign grant_id  = r_grant_id;
    assign busy      = r_busy;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: framing, round-robin ties, mid-frame reset and ready gating.
module tb_piso_tx_ctrl;

    localparam int W = 4;
`ifdef PISO_TX_PARITY_EN
    localparam int FRAME = W + 1;
`else
    localparam int FRAME = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         req0_valid;
    logic [W-1:0] req0_data;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_data;
    logic         req1_ready;
    logic         ser_out;
    logic         ser_valid;
    logic         ser_first;
    logic         ser_last;
    logic         grant_id;
    logic         busy;

    int assertCount = 0;
    int failCount   = 0;

    piso_tx_ctrl #(
        .WIDTH (W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_ready (req1_ready),
        .ser_out    (ser_out),
        .ser_valid  (ser_valid),
        .ser_first  (ser_first),
        .ser_last   (ser_last),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [W-1:0] d0, input logic v1, input logic [W-1:0] d1);
        req0_valid = v0;
        req0_data  = d0;
        req1_valid = v1;
        req1_data  = d1;
    endtask

    // Asserts reset with both requesters valid, checks every output is cleared at once, then releases.
    task automatic doReset(input string tag);
        rst_n = 1'b0;
        applyStimulus(1'b1, 4'hF, 1'b1, 4'hF);
        #1;
        checkOutput({tag, "_ser_out"},   ser_out,    0);
        checkOutput({tag, "_ser_valid"}, ser_valid,  0);
        checkOutput({tag, "_ser_first"}, ser_first,  0);
        checkOutput({tag, "_ser_last"},  ser_last,   0);
        checkOutput({tag, "_grant_id"},  grant_id,   0);
        checkOutput({tag, "_busy"},      busy,       0);
        checkOutput({tag, "_ready0"},    req0_ready, 0);
        checkOutput({tag, "_ready1"},    req1_ready, 0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Waits (bounded) for a handshake; returns just after the accepting edge.
    task automatic waitHandshake(input string tag, input int expWait, input logic expWho);
        int   cycles = 0;
        logic seen   = 1'b0;
        while (!seen && cycles < 20) begin
            @(negedge clk);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                seen = 1'b1;
                checkOutput({tag, "_who"},       req1_ready, expWho);
                checkOutput({tag, "_onehot"},    req0_ready & req1_ready, 0);
                checkOutput({tag, "_wait"},      cycles, expWait);
                checkOutput({tag, "_gap_valid"}, ser_valid, 0);
                checkOutput({tag, "_gap_busy"},  busy, 0);
            end else begin
                cycles++;
            end
        end
        if (!seen) begin
            checkOutput({tag, "_timeout"}, 0, 1);
        end
        @(posedge clk);
        #1;
    endtask

    // Checks one whole frame starting in the cycle after the handshake edge.
    task automatic checkFrame(input string tag, input logic [W-1:0] word, input logic gid);
        logic expBit;
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            expBit = (i < W) ? word[W-1-i] : ^word;
            checkOutput($sformatf("%s_b%0d_out", tag, i),   ser_out,    expBit);
            checkOutput($sformatf("%s_b%0d_valid", tag, i), ser_valid,  1);
            checkOutput($sformatf("%s_b%0d_first", tag, i), ser_first,  (i == 0));
            checkOutput($sformatf("%s_b%0d_last", tag, i),  ser_last,   (i == FRAME - 1));
            checkOutput($sformatf("%s_b%0d_busy", tag, i),  busy,       1);
            checkOutput($sformatf("%s_b%0d_gid", tag, i),   grant_id,   gid);
            checkOutput($sformatf("%s_b%0d_rdy0", tag, i),  req0_ready, 0);
            checkOutput($sformatf("%s_b%0d_rdy1", tag, i),  req1_ready, 0);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        #2;
        doReset("rst0");

        // Single req0 word
        applyStimulus(1'b1, 4'b1011, 1'b0, 4'h0);
        waitHandshake("t1_hs", 0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkFrame("t1", 4'b1011, 1'b0);

        // Both requesters held: req0, req1, req0
        doReset("rst1");
        applyStimulus(1'b1, 4'hA, 1'b1, 4'h5);
        waitHandshake("t2_hs0", 0, 1'b0);
        checkFrame("t2_f0", 4'hA, 1'b0);
        waitHandshake("t2_hs1", 0, 1'b1);
        checkFrame("t2_f1", 4'h5, 1'b1);
        waitHandshake("t2_hs2", 0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkFrame("t2_f2", 4'hA, 1'b0);

        // req1 alone, back-to-back
        doReset("rst2");
        applyStimulus(1'b0, 4'h0, 1'b1, 4'hF);
        for (int k = 0; k < 3; k++) begin
            waitHandshake($sformatf("t3_hs%0d", k), 0, 1'b1);
            if (k == 2) begin
                applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
            end
            checkFrame($sformatf("t3_f%0d", k), 4'hF, 1'b1);
        end

        // Reset at the second bit of a 4'hC frame, then a tie
        doReset("rst3");
        applyStimulus(1'b1, 4'hC, 1'b0, 4'h0);
        waitHandshake("t4_hs", 0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        @(negedge clk);
        checkOutput("t4_b0_out",   ser_out,   1);
        checkOutput("t4_b0_first", ser_first, 1);
        @(posedge clk);
        #1;
        checkOutput("t4_b1_valid", ser_valid, 1);
        doReset("t4_midrst");
        applyStimulus(1'b1, 4'h3, 1'b1, 4'h6);
        waitHandshake("t4_tie", 0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkFrame("t4_f", 4'h3, 1'b0);

        // req1 raises valid mid-frame; accepted at the first idle cycle
        applyStimulus(1'b1, 4'b1011, 1'b0, 4'h0);
        waitHandshake("t5_hs0", 0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h6);
        checkFrame("t5_f0", 4'b1011, 1'b0);
        waitHandshake("t5_hs1", 0, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkFrame("t5_f1", 4'h6, 1'b1);

        // All-zero word
        applyStimulus(1'b1, 4'b0000, 1'b0, 4'h0);
        waitHandshake("t6_hs", 0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0);
        checkFrame("t6_zero", 4'b0000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/piso_tx_ctrl.md
# piso_tx_ctrl

Sequencing controller for the team's parallel-in/serial-out shifter. Accepts parallel words from two requesters over valid/ready handshakes and arbitrates between them round-robin. Drives an internal PISO shifter to emit each word MSB-first on a single serial line, with frame-position strobes. Sits between word-producing logic and any bit-serial output path.

## Interface
- WIDTH, 4: word width in bits, ≥2.
- CNT_W, derived localparam $clog2(WIDTH+1): bit-counter width, not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle.
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle.
- ser_out  out  1  serial data bit.
- ser_valid  out  1  ser_out carries a frame bit.
- ser_first  out  1  first bit of frame.
- ser_last  out  1  last bit of frame.
- grant_id  out  1  source of the frame in flight.
- busy  out  1  frame in progress (state ≠ IDLE).

## Operation
- FSM states:
  - IDLE: ser_* outputs 0.
  - SHIFT: emit WIDTH data bits.
  - PARITY: only with the macro; emit 1 parity bit.
- IDLE → SHIFT on any handshake (valid & ready at the clock edge).
- SHIFT → PARITY (macro) or IDLE when the bit counter reaches WIDTH-1.
- PARITY → IDLE unconditionally.
- Handshakes occur only in IDLE; ready is 0 in every other state.
- Ready is combinational from valid and the arbitration pointer; valid must not depend on ready.
- Requesters hold valid and data stable until accepted.
- Arbitration:
  - A sole valid requester wins.
  - When both are valid, the winner is the requester not granted last.
  - The last-grant pointer resets to 1, so req0 wins the first tie.
  - At most one ready is high per cycle.
- On handshake:
  - The word is loaded into the shifter.
  - grant_id latches the winner and holds until the next handshake.
  - The bit counter clears.
- Each SHIFT cycle presents shifter MSB on ser_out, then shifts left, zero-filling.
- Reset (any time, including mid-frame), all outputs and state:
  - Outputs: ser_out, ser_valid, ser_first, ser_last, grant_id, busy = 0; ready = 0 while rst_n is low.
  - Internal: shifter = 0, counter = 0, pointer = 1, state = IDLE.
  - A partial frame is abandoned; it is not resumed.
- Idle valid with no handshake: no effect.

## Timing
- All outputs except reqX_ready are registered.
- Handshake at edge N: the frame occupies cycles N+1 … N+WIDTH (+1 with parity).
  - ser_valid = 1 throughout.
  - ser_first at N+1.
  - ser_last on the final frame cycle.
  - busy = 1 throughout.
- Bit k (MSB = bit WIDTH-1) appears at cycle N+1+(WIDTH-1-k).
- Earliest next handshake: cycle N+WIDTH+1 (N+WIDTH+2 with parity). One idle cycle separates frames, with ser_valid = 0.
- Throughput: 1 word per WIDTH+1 cycles (WIDTH+2 with parity).

## Configuration
- PISO_TX_PARITY_EN defined:
  - PARITY state is compiled in.
  - Even-parity bit (XOR of the word, captured at load) is appended after the LSB.
  - ser_last moves to the parity cycle.
  - Frame length is WIDTH+1.
- PISO_TX_PARITY_EN undefined:
  - No PARITY state or parity register.
  - Frame length is WIDTH.

## Structure
- Package piso_tx_pkg holds:
  - the state enum (IDLE, SHIFT, PARITY);
  - the default WIDTH constant;
  - the grant-id encoding constants (REQ0 = 0, REQ1 = 1).
- Sub-module piso_shifter: WIDTH-bit load/shift-left register with async active-low clear, exposing MSB. The controller owns all sequencing.

## Test plan
- Reset then WIDTH=4, req0 sends 4'b1011 at edge N → ser_out 1,0,1,1 on N+1..N+4; ser_first at N+1; ser_last at N+4; grant_id=0; req0_ready=0 during N+1..N+4.
- Both valid from reset, req0=4'hA, req1=4'h5, held → frames 1010 then 0101 with one idle cycle between; grant_id 0 then 1; the next tie goes to req0.
- req1 alone, valid held continuously with 4'hF → back-to-back frames every 5 cycles, each 1111, with ser_valid gap cycles at 0.
- rst_n pulsed low at the second bit of a 4'hC frame → all outputs 0 immediately; after release, a req1/req0 tie grants req0.
- Macro defined, req0 sends 4'b1011 → ser_out 1,0,1,1,1; ser_last on the 5th bit; 4'b0000 gives parity bit 0.
- Valid asserted during SHIFT → no ready until IDLE; data is accepted at exactly N+WIDTH+1.
